// File: rtl/inst_sram_axi_bridge_if.sv
// Bundles for the bridge: the core's inst_sram request/response port and the AXI read-address/read-data channels.
// inst_sram_if: master = core, slave = bridge.  axi_rd_if: master = bridge, slave = interconnect/memory.
interface inst_sram_if #(
  parameter int ADDR_W = 32
);
  logic              en;
  logic [3:0]        wen;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;

  modport master (output en, wen, addr, size, input addr_ok, data_ok, rdata);
  modport slave  (input en, wen, addr, size, output addr_ok, data_ok, rdata);
endinterface

interface axi_rd_if #(
  parameter int ADDR_W = 32
);
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [3:0]        rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
                  input  arready, rid, rdata, rresp, rlast, rvalid);
  modport slave  (input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
                  output arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/inst_sram_axi_bridge.sv
// Instruction SRAM-like to AXI read bridge: one outstanding single-beat read, request latched at addr_ok.
// Latency addr_ok->data_ok >= 2 cycles (3 with INST_BRIDGE_RDATA_BUF_EN, which registers the read data).
module inst_sram_axi_bridge #(
  parameter logic [3:0] ARID   = 4'd0,
  parameter int         ADDR_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  inst_sram_if.slave  inst_sram,
  axi_rd_if.master    axi
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] R    = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              beat_last;

  assign beat_last = axi.rvalid & axi.rlast;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (inst_sram.en) state_nxt = AR;
      AR:   if (axi.arready)  state_nxt = R;
`ifdef INST_BRIDGE_RDATA_BUF_EN
      R:    if (beat_last)    state_nxt = RSP;
`else
      R:    if (beat_last)    state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      size_q <= '0;
    end else begin
      state <= state_nxt;
      // The core may move its request after addr_ok; AR fields come only from these registers.
      if (state == IDLE && inst_sram.en) begin
        addr_q <= inst_sram.addr;
        size_q <= inst_sram.size;
      end
    end
  end

  assign inst_sram.addr_ok = (state == IDLE) & inst_sram.en & ~reset;

`ifdef INST_BRIDGE_RDATA_BUF_EN
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset)
      rdata_q <= '0;
    else if (state == R && beat_last)
      rdata_q <= axi.rdata;
  end

  assign inst_sram.data_ok = (state == RSP) & ~reset;
  assign inst_sram.rdata   = rdata_q;
`else
  assign inst_sram.data_ok = (state == R) & beat_last & ~reset;
  assign inst_sram.rdata   = axi.rdata;
`endif

  assign axi.arid    = ARID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = (state == AR);
  assign axi.rready  = (state == R);

  // Every access is a read and errors are not reported, so these inputs carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, inst_sram.wen, axi.rid, axi.rresp};

endmodule
